// File: rtl/cell_dac_output_stage.sv
// DAC output stage: clamp and slew-limit controller samples, hold the latest one
// in a single-entry buffer, and shift each as an offset-binary frame to a serial DAC.
module cell_dac_output_stage #(
  parameter int VOL_MSB = 14,
  parameter int CLK_DIV = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               param_en,
  input  logic [VOL_MSB:0]   lim_hi,
  input  logic [VOL_MSB:0]   lim_lo,
  input  logic [VOL_MSB:0]   max_step,
  input  logic [VOL_MSB:0]   data,
  input  logic               data_en,
  output logic               dac_sclk,
  output logic               dac_sdin,
  output logic               dac_cs_n,
  output logic               busy,
  output logic [15:0]        overrun_cnt
);

  localparam int W     = VOL_MSB + 1;
  localparam int FRAME = W + 1;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

  // ---------------- parameter registers ----------------
  logic [W-1:0] lim_hi_q, lim_lo_q, max_step_q;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every register samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lim_hi_q   <= {1'b0, {(W-1){1'b1}}};
      lim_lo_q   <= {1'b1, {(W-1){1'b0}}};
      max_step_q <= '0;
    end else if (param_en) begin
      lim_hi_q   <= lim_hi;
      lim_lo_q   <= lim_lo;
      max_step_q <= max_step;
    end
  end

  // ---------------- stage 1: clamp ----------------
  logic [W-1:0] clamp_d, clamp_q;
  logic         clamp_vld_q;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    clamp_d = data;
    if ($signed(data) > $signed(lim_hi_q))
      clamp_d = lim_hi_q;
    else if ($signed(data) < $signed(lim_lo_q))
      clamp_d = lim_lo_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clamp_q     <= '0;
      clamp_vld_q <= 1'b0;
    end else begin
      clamp_vld_q <= data_en;
      if (data_en)
        clamp_q <= clamp_d;
    end
  end

  // ---------------- stage 2: slew limit ----------------
  logic [W-1:0] last_out_q, slew_d;
  logic [W:0]   diff, diff_abs;

  // diff is sign-extended by one bit so a full-scale swing cannot wrap
  always_comb begin
    diff     = {clamp_q[W-1], clamp_q} - {last_out_q[W-1], last_out_q};
    diff_abs = diff[W] ? -diff : diff;
    slew_d   = clamp_q;
    if ((max_step_q != '0) && (diff_abs > {1'b0, max_step_q}))
      slew_d = diff[W] ? (last_out_q - max_step_q) : (last_out_q + max_step_q);
  end

  // ---------------- pending buffer ----------------
  state_t       state_q, state_d;
  logic         pend_q;
  logic [W-1:0] pend_data_q;
  logic [15:0]  overrun_q;
  logic         consume;

  assign consume = (state_q == S_IDLE) && pend_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_out_q  <= '0;
      pend_data_q <= '0;
      pend_q      <= 1'b0;
      overrun_q   <= '0;
    end else if (clamp_vld_q) begin
      last_out_q  <= slew_d;
      pend_data_q <= slew_d;
      pend_q      <= 1'b1;
      if (pend_q && !consume && (overrun_q != 16'hFFFF))
        overrun_q <= overrun_q + 16'd1;
    end else if (consume) begin
      pend_q <= 1'b0;
    end
  end

  // write command bit, then the sample in offset binary
  logic [FRAME-1:0] frame_d;
  assign frame_d = {1'b0, ~pend_data_q[W-1], pend_data_q[W-2:0]};

  // ---------------- serializer ----------------
  logic [DIV_W-1:0] div_q, div_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [FRAME-1:0] shift_q, shift_d;
  logic             sclk_q, sclk_d, cs_n_q, cs_n_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          state_d = S_SHIFT;
          shift_d = frame_d;
          div_d   = '0;
          bit_d   = '0;
          sclk_d  = 1'b0;
          cs_n_d  = 1'b0;
        end
      end
      S_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // falling edge: advance to the next bit or close the frame
            sclk_d = 1'b0;
            if (bit_q == BIT_LAST) begin
              state_d = S_GAP;
              cs_n_d  = 1'b1;
            end else begin
              bit_d   = bit_q + 1'b1;
              shift_d = {shift_q[FRAME-2:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        sclk_d  = 1'b0;
        cs_n_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
    end
  end

  assign dac_sclk    = sclk_q;
  assign dac_cs_n    = cs_n_q;
  assign dac_sdin    = ~cs_n_q & shift_q[FRAME-1];
  assign busy        = (state_q != S_IDLE) | pend_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_cell_dac_output_stage.sv
// Scoreboard bench for cell_dac_output_stage: directed samples push their expected
// frame; a negedge monitor deserializes each DAC frame and pops/compares it.
module tb_cell_dac_output_stage;

  logic        clk, rst, param_en, data_en;
  logic [14:0] lim_hi, lim_lo, max_step, data;
  logic        dac_sclk, dac_sdin, dac_cs_n, busy;
  logic [15:0] overrun_cnt;

  int          n_vec, n_err;
  logic [15:0] exp_q[$];
  bit          bypass, watch_busy, busy_dropped;

  cell_dac_output_stage #(.VOL_MSB(14), .CLK_DIV(4)) dut (
    .clk(clk), .rst(rst), .param_en(param_en),
    .lim_hi(lim_hi), .lim_lo(lim_lo), .max_step(max_step),
    .data(data), .data_en(data_en),
    .dac_sclk(dac_sclk), .dac_sdin(dac_sdin), .dac_cs_n(dac_cs_n),
    .busy(busy), .overrun_cnt(overrun_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_params(input logic [14:0] hi, input logic [14:0] lo, input logic [14:0] step);
    lim_hi = hi; lim_lo = lo; max_step = step; param_en = 1'b1;
    tick();
    param_en = 1'b0;
  endtask

  task automatic send(input logic [14:0] v, input logic [15:0] exp_frame, input bit push = 1'b1);
    data = v; data_en = 1'b1;
    if (push) exp_q.push_back(exp_frame);
    tick();
    data_en = 1'b0;
  endtask

  task automatic send_p(input logic [14:0] v, input logic [15:0] exp_frame,
                        input logic [14:0] hi, input logic [14:0] lo, input logic [14:0] step);
    lim_hi = hi; lim_lo = lo; max_step = step; param_en = 1'b1;
    data = v; data_en = 1'b1;
    exp_q.push_back(exp_frame);
    tick();
    data_en = 1'b0; param_en = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    repeat (2) tick();
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check(name, busy, 0);
  endtask

  // frame monitor
  initial begin
    logic        prev_cs, prev_sclk;
    int          low_cnt, edge_cnt;
    logic [15:0] shreg, e;
    prev_cs = 1'b1; prev_sclk = 1'b0; low_cnt = 0; edge_cnt = 0; shreg = '0;
    forever begin
      @(negedge clk);
      if (watch_busy && !busy) busy_dropped = 1'b1;
      if (rst) begin
        prev_cs = 1'b1; prev_sclk = 1'b0; low_cnt = 0; edge_cnt = 0; shreg = '0;
      end else begin
        if (!dac_cs_n) begin
          low_cnt++;
          if (dac_sclk && !prev_sclk) begin
            edge_cnt++;
            shreg = {shreg[14:0], dac_sdin};
          end
        end
        if (dac_cs_n && !prev_cs && !bypass) begin
          if (exp_q.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL frame_unexpected: got 0x%h, expected no frame", shreg);
          end else begin
            e = exp_q.pop_front();
            check("frame", shreg, e);
            check("frame_edges", edge_cnt, 16);
            check("frame_cs_low", low_cnt, 128);
          end
        end
        if (dac_cs_n) begin
          low_cnt = 0; edge_cnt = 0;
        end
        prev_cs = dac_cs_n; prev_sclk = dac_sclk;
      end
    end
  end

  initial begin
    bit cs_seen;
    n_vec = 0; n_err = 0;
    bypass = 1'b0; watch_busy = 1'b0; busy_dropped = 1'b0;
    rst = 1'b1; param_en = 1'b0; data_en = 1'b0;
    lim_hi = '0; lim_lo = '0; max_step = '0; data = '0;

    // reset state
    repeat (3) tick();
    check("rst_cs_n", dac_cs_n, 1);
    check("rst_sclk", dac_sclk, 0);
    check("rst_sdin", dac_sdin, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun_cnt, 0);
    rst = 1'b0;
    repeat (2) tick();
    check("post_rst_cs_n", dac_cs_n, 1);

    // first frame latency and shape
    send(15'h0100, 16'h4100);
    check("lat_n1_cs_n", dac_cs_n, 1);
    tick();
    check("lat_n2_cs_n", dac_cs_n, 1);
    check("lat_n2_busy", busy, 1);
    tick();
    check("lat_n3_cs_n", dac_cs_n, 0);
    check("lat_n3_sdin", dac_sdin, 0);
    wait_idle("t1_idle");

    // clamp limits
    set_params(15'h0800, 15'h7800, 15'h0000);
    send(15'h1000, 16'h4800); wait_idle("clamp_hi_idle");
    send(15'h7000, 16'h3800); wait_idle("clamp_lo_idle");

    // slew limiting from last_out = 0
    set_params(15'h3FFF, 15'h4000, 15'h0000);
    send(15'h0000, 16'h4000); wait_idle("slew_zero_idle");
    set_params(15'h3FFF, 15'h4000, 15'h0010);
    send(15'h0100, 16'h4010); wait_idle("slew1_idle");
    send(15'h0100, 16'h4020); wait_idle("slew2_idle");
    send(15'h0100, 16'h4030); wait_idle("slew3_idle");
    set_params(15'h3FFF, 15'h4000, 15'h0000);
    send(15'h0000, 16'h4000); wait_idle("slew_rezero_idle");
    set_params(15'h3FFF, 15'h4000, 15'h0010);
    send(15'h7F00, 16'h3FF0); wait_idle("slew_neg_idle");

    // overrun: A, B, C five cycles apart -> A and C framed
    set_params(15'h3FFF, 15'h4000, 15'h0000);
    send(15'h0123, 16'h4123);
    tick();
    watch_busy = 1'b1;
    repeat (3) tick();
    send(15'h0456, 16'h0000, 1'b0);
    repeat (4) tick();
    send(15'h0789, 16'h4789);
    tick();
    check("overrun_one", overrun_cnt, 1);
    repeat (244) tick();
    watch_busy = 1'b0;
    check("busy_held", busy_dropped, 0);
    wait_idle("overrun_idle");

    // overrun counter saturation
    bypass = 1'b1;
    data = 15'h0000; data_en = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    data_en = 1'b0;
    wait_idle("flood_idle");
    bypass = 1'b0;
    check("overrun_sat", overrun_cnt, 16'hFFFF);

    // reset during bit 8 (high phase)
    send(15'h0200, 16'h4200);
    repeat (2) tick();
    repeat (69) tick();
    check("midframe_cs_n", dac_cs_n, 0);
    check("midframe_sclk", dac_sclk, 1);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("async_rst_cs_n", dac_cs_n, 1);
    check("async_rst_sclk", dac_sclk, 0);
    repeat (2) tick();
    rst = 1'b0;
    check("rst2_overrun", overrun_cnt, 0);
    check("rst2_busy", busy, 0);
    cs_seen = 1'b0;
    repeat (300) begin
      tick();
      if (!dac_cs_n) cs_seen = 1'b1;
    end
    check("no_resume", cs_seen, 0);
    set_params(15'h3FFF, 15'h4000, 15'h0010);
    send(15'h0100, 16'h4010); wait_idle("post_rst_idle");

    // param_en on same cycle as data_en
    set_params(15'h3FFF, 15'h4000, 15'h0000);
    send_p(15'h0100, 16'h4100, 15'h0050, 15'h4000, 15'h0000); wait_idle("same_cyc_idle");
    send(15'h0100, 16'h4050); wait_idle("new_lim_idle");

    // inverted limits: hi test wins
    set_params(15'h0010, 15'h0020, 15'h0000);
    send(15'h0015, 16'h4010); wait_idle("inv_hi_idle");
    send(15'h0005, 16'h4020); wait_idle("inv_lo_idle");

    // full-scale codes and full-scale slew
    set_params(15'h3FFF, 15'h4000, 15'h0000);
    send(15'h3FFF, 16'h7FFF); wait_idle("fs_pos_idle");
    send(15'h4000, 16'h0000); wait_idle("fs_neg_idle");
    set_params(15'h3FFF, 15'h4000, 15'h0010);
    send(15'h3FFF, 16'h0010); wait_idle("fs_slew_idle");
    send(15'h4020, 16'h0020); wait_idle("slew_eq_idle");

    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cell_dac_output_stage.md
# cell_dac_output_stage

Downstream output stage of the control systems coprocessor. It consumes the controller's `data_out`/`data_out_en` sample stream and applies programmable clamp limits and slew-rate limiting. It then serializes each conditioned sample as an offset-binary frame to an external serial DAC. A one-deep latest-wins buffer decouples the sample rate from the DAC frame rate and counts dropped samples.

## Interface
- `VOL_MSB`, 14: MSB index of signed two's-complement sample; sample width W = VOL_MSB+1.
- `CLK_DIV`, 4: `clk` cycles per SCLK half-period (≥1).
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous, active-high.
- `param_en` in 1: capture `lim_hi`, `lim_lo`, `max_step` this cycle.
- `lim_hi` in W: signed upper clamp.
- `lim_lo` in W: signed lower clamp.
- `max_step` in W: unsigned max change per sample; 0 = slew limit disabled.
- `data` in W: signed sample from controller.
- `data_en` in 1: `data` valid, single-cycle strobe.
- `dac_sclk` out 1: serial clock; the DAC samples on the rising edge.
- `dac_sdin` out 1: serial data, MSB first.
- `dac_cs_n` out 1: frame select, active-low.
- `busy` out 1: high when the state is not IDLE or the pending buffer is full.
- `overrun_cnt` out 16: count of overwritten pending samples, saturating.

## Operation
- **Parameter registers**
  - Loaded on `param_en`.
  - Reset values: `lim_hi` = +2^VOL_MSB−1, `lim_lo` = −2^VOL_MSB, `max_step` = 0.
  - New values apply to the first sample clamped after the capture cycle.
- **Stage 1, clamp** (registered on `data_en`):
  - Result is `lim_hi` if `data` > `lim_hi`, else `lim_lo` if `data` < `lim_lo`, else `data`.
  - Comparisons are signed.
  - With `lim_lo` > `lim_hi`, the hi test has priority.
- **Stage 2, slew** (registered one cycle after stage 1):
  - Compute diff = target − `last_out` in W+1 signed bits.
  - If `max_step` ≠ 0 and |diff| > `max_step`, then `last_out` ← `last_out` ± `max_step` (sign of diff).
  - Otherwise `last_out` ← target.
  - `last_out` resets to 0. The result never overflows because both operands lie within the clamp range.
- **Pending buffer**: stage 2 writes `last_out` into a one-entry buffer and sets `pend`.
  - If `pend` is already set and not consumed this cycle, the entry is overwritten and `overrun_cnt` increments, saturating at 0xFFFF.
  - If the serializer consumes and stage 2 writes in the same cycle, the new entry is kept and no overrun is counted.
- **Frame format**: FRAME = W+1 bits.
  - Bit W = 0 (write command).
  - Bits W−1..0 = sample with bit VOL_MSB inverted (offset binary).
  - Examples at the defaults: 0 → 0x4000, +0x3FFF → 0x7FFF, −0x4000 → 0x0000.
- **Serializer FSM**
  - IDLE: `cs_n`=1, `sclk`=0. If `pend`, load the shift register, clear `pend`, and go to SHIFT.
  - SHIFT: `cs_n`=0, `sdin` = shift register MSB. Each bit is CLK_DIV cycles with `sclk` low, then CLK_DIV cycles with `sclk` high. The shift register advances as `sclk` falls. After the high phase of the last bit, go to GAP.
  - GAP: `cs_n`=1, `sclk`=0 for CLK_DIV cycles, then go to IDLE.

## Timing
- Reset values: `dac_sclk` 0, `dac_sdin` 0, `dac_cs_n` 1, `busy` 0, `overrun_cnt` 0, `pend` 0, state IDLE.
- Asserting reset mid-frame drives `cs_n` high asynchronously and abandons the frame; nothing resumes after release.
- Latency:
  - `data_en` at cycle N → clamp register at N+1 → `pend` at N+2.
  - If IDLE, `cs_n` falls at N+3 with the first bit on `sdin`.
- `cs_n` is low for exactly 2·CLK_DIV·FRAME cycles: 128 at the defaults (FRAME = 16).
- Minimum frame-to-frame period: 2·CLK_DIV·FRAME + CLK_DIV + 1 cycles (133 at the defaults).
- `sdin` is stable for the full SCLK high phase, giving CLK_DIV cycles of setup and hold around each rising edge.
- Exactly FRAME rising edges of `sclk` occur per `cs_n`-low window.

## Test plan
- Reset, then `data`=0x0100 with `data_en` and default parameters → `cs_n` falls 3 cycles later; frame shifted is 0x4100; 16 rising edges; `cs_n` low for 128 cycles; `busy` drops after GAP.
- Set `lim_hi`=0x0800 and `lim_lo`=0x7800 (−0x0800). Input 0x1000 → frame 0x4800. Input 0x7000 → frame 0x3800.
- Set `max_step`=0x0010, `last_out`=0, and input 0x0100 spaced >133 cycles apart → frames 0x4010, 0x4020, 0x4030… Then input 0x7F00 (−0x0100) from 0 → 0x3FF0.
- Issue three `data_en` (values A, B, C) 5 cycles apart → only A and C are framed; `overrun_cnt`=1; `busy` stays high throughout. Drive 70000 overruns → counter holds 0xFFFF.
- Assert `rst` during bit 8 of a frame → `cs_n`=1 and `sclk`=0 in the same cycle. After release there is no frame until a new `data_en`, and the next frame reflects `last_out` reset to 0 (with slew active).
- Pulse `param_en` with a new `lim_hi` on the same cycle as `data_en` → that sample uses the old limit and the next sample uses the new one.
